// File: rtl/timer_irq.sv
// Memory-mapped interval timer with reload, prescaler, level interrupt and a
// free-running cycle counter, sitting on the MIPS data-memory bus.
module timer_irq #(
  parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1            // 1..65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Interrupt
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic [15:0] presc;

  logic sel_th, sel_tl, sel_tcon, sel_systick;
  logic wr_th, wr_tl, wr_tcon;
  logic tick, overflow, status_set;

  assign sel_th      = (Addr == ADDR_BASE);
  assign sel_tl      = (Addr == ADDR_BASE + 32'h04);
  assign sel_tcon    = (Addr == ADDR_BASE + 32'h08);
  assign sel_systick = (Addr == ADDR_BASE + 32'h14);

  assign wr_th   = MemWr && sel_th;
  assign wr_tl   = MemWr && sel_tl;
  assign wr_tcon = MemWr && sel_tcon;

  assign tick       = tcon[0] && (presc == PRESC_LAST);
  assign overflow   = tick && (tl == '1);
  assign status_set = overflow && tcon[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc <= '0;
    else if (!tcon[0] || tick)
      presc <= '0;
    else
      presc <= presc + 16'd1;
  end

  // Reload reads the current TH, so a same-edge TH write only affects later reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      th <= '0;
    else if (wr_th)
      th <= WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tl <= '0;
    else if (wr_tl)
      tl <= WriteData;
    else if (tick)
      tl <= overflow ? th : tl + 32'd1;
  end

  // A hardware status set on the same edge as a software TCON write is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tcon <= '0;
    else if (wr_tcon)
      tcon <= {WriteData[2] | status_set, WriteData[1:0]};
    else if (status_set)
      tcon[2] <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      systick <= '0;
    else
      systick <= systick + 32'd1;
  end

  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      if (sel_th)
        ReadData = th;
      else if (sel_tl)
        ReadData = tl;
      else if (sel_tcon)
        ReadData = {29'd0, tcon};
      else if (sel_systick)
        ReadData = systick;
    end
  end

  assign Interrupt = tcon[1] & tcon[2];

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: one instance with PRESCALE=1, one with
// PRESCALE=4 on a different base, sharing the bus.
module tb_timer_irq;

  localparam logic [31:0] A_BASE = 32'h4000_0000;
  localparam logic [31:0] B_BASE = 32'h5000_0000;
  localparam logic [31:0] A_TH   = A_BASE + 32'h00;
  localparam logic [31:0] A_TL   = A_BASE + 32'h04;
  localparam logic [31:0] A_TCON = A_BASE + 32'h08;
  localparam logic [31:0] A_SYS  = A_BASE + 32'h14;
  localparam logic [31:0] B_TL   = B_BASE + 32'h04;
  localparam logic [31:0] B_TCON = B_BASE + 32'h08;

  logic        clk;
  logic        reset;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned cycles;

  timer_irq #(.ADDR_BASE(A_BASE), .PRESCALE(1)) u_dut_a (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
    .WriteData(WriteData), .ReadData(rd_a), .Interrupt(irq_a)
  );

  timer_irq #(.ADDR_BASE(B_BASE), .PRESCALE(4)) u_dut_b (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
    .WriteData(WriteData), .ReadData(rd_b), .Interrupt(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for SYSTICK: clock edges seen since reset released.
  always @(posedge clk or posedge reset) begin
    if (reset) cycles <= 0;
    else       cycles <= cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWr = 1'b1;
    Addr = a;
    WriteData = d;
    step();
    MemWr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemRd = 1'b1;
    Addr = a;
    #1;
    check_eq(tag, (a[31:28] == 4'h4) ? rd_a : rd_b, exp);
    MemRd = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    MemRd = 1'b0;
    MemWr = 1'b0;
    Addr = '0;
    WriteData = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_chk("rst_th", A_TH, 32'h0);
    rd_chk("rst_tcon", A_TCON, 32'h0);
    check_eq("rst_irq", {31'd0, irq_a}, 32'h0);
    reset = 1'b0;

    // Basic overflow, PRESCALE=1
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFD);
    wr(A_TCON, 32'h3);
    rd_chk("ovf_tl0", A_TL, 32'hFFFF_FFFD);
    step();
    rd_chk("ovf_tl1", A_TL, 32'hFFFF_FFFE);
    check_eq("ovf_irq1", {31'd0, irq_a}, 32'h0);
    step();
    rd_chk("ovf_tl2", A_TL, 32'hFFFF_FFFF);
    check_eq("ovf_irq2", {31'd0, irq_a}, 32'h0);
    step();
    rd_chk("ovf_tl3", A_TL, 32'hFFFF_FFFD);
    check_eq("ovf_irq3", {31'd0, irq_a}, 32'h1);
    rd_chk("ovf_tcon", A_TCON, 32'h7);

    // Handler clear and next overflow three edges after reload
    wr(A_TCON, 32'h3);
    check_eq("clr_irq", {31'd0, irq_a}, 32'h0);
    rd_chk("clr_tcon", A_TCON, 32'h3);
    rd_chk("clr_tl", A_TL, 32'hFFFF_FFFE);
    step();
    check_eq("clr_irq2", {31'd0, irq_a}, 32'h0);
    step();
    rd_chk("ovf2_tl", A_TL, 32'hFFFF_FFFD);
    check_eq("ovf2_irq", {31'd0, irq_a}, 32'h1);

    // TCON write colliding with overflow
    wr(A_TCON, 32'h3);
    step();
    rd_chk("col_pre_tl", A_TL, 32'hFFFF_FFFF);
    check_eq("col_pre_irq", {31'd0, irq_a}, 32'h0);
    wr(A_TCON, 32'h3);
    rd_chk("col_tcon", A_TCON, 32'h7);
    check_eq("col_irq", {31'd0, irq_a}, 32'h1);

    // TL write on a tick edge wins
    wr(A_TL, 32'h5);
    rd_chk("col_tl", A_TL, 32'h5);
    step();
    rd_chk("tl_inc", A_TL, 32'h6);

    // TH write on overflow edge: reload uses old TH
    wr(A_TL, 32'hFFFF_FFFE);
    step();
    wr(A_TH, 32'h100);
    rd_chk("th_col_tl", A_TL, 32'hFFFF_FFFD);
    rd_chk("th_col_th", A_TH, 32'h100);

    // Overflow with irq enable clear reloads but sets no status
    wr(A_TCON, 32'h1);
    check_eq("ie0_irq", {31'd0, irq_a}, 32'h0);
    step();
    step();
    rd_chk("ie0_tl", A_TL, 32'h100);
    rd_chk("ie0_tcon", A_TCON, 32'h1);

    // Prescaler, PRESCALE=4
    wr(B_TL, 32'h0);
    wr(B_TCON, 32'h1);
    repeat (3) step();
    rd_chk("psc_3", B_TL, 32'h0);
    step();
    rd_chk("psc_4", B_TL, 32'h1);
    repeat (3) step();
    rd_chk("psc_7", B_TL, 32'h1);
    step();
    rd_chk("psc_8", B_TL, 32'h2);
    step();
    wr(B_TCON, 32'h0);
    step();
    wr(B_TCON, 32'h1);
    repeat (3) step();
    rd_chk("psc_re3", B_TL, 32'h2);
    step();
    rd_chk("psc_re4", B_TL, 32'h3);
    check_eq("psc_irq", {31'd0, irq_b}, 32'h0);

    // Bus decode
    rd_chk("dec_0c", A_BASE + 32'h0C, 32'h0);
    rd_chk("dec_18", A_BASE + 32'h18, 32'h0);
    rd_chk("dec_unal", A_BASE + 32'h01, 32'h0);
    MemRd = 1'b0;
    Addr = A_TH;
    #1;
    check_eq("rd_off", rd_a, 32'h0);

    rd_chk("sys0", A_SYS, cycles);
    wr(A_SYS, 32'h1234_5678);
    rd_chk("sys_wr", A_SYS, cycles);
    step();
    rd_chk("sys_inc", A_SYS, cycles);

    // Simultaneous read and write shows pre-write value
    MemRd = 1'b1;
    MemWr = 1'b1;
    Addr = A_TH;
    WriteData = 32'hCAFE_0000;
    #1;
    check_eq("rw_old", rd_a, 32'h100);
    @(posedge clk);
    #1;
    MemWr = 1'b0;
    check_eq("rw_new", rd_a, 32'hCAFE_0000);
    MemRd = 1'b0;

    // Asynchronous reset mid-count
    wr(A_TCON, 32'h3);
    #2;
    reset = 1'b1;
    rd_chk("ar_th", A_TH, 32'h0);
    rd_chk("ar_tl", A_TL, 32'h0);
    rd_chk("ar_tcon", A_TCON, 32'h0);
    rd_chk("ar_sys", A_SYS, 32'h0);
    rd_chk("ar_btl", B_TL, 32'h0);
    check_eq("ar_irq", {31'd0, irq_a}, 32'h0);
    step();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
